// File: rtl/inv_clark_tf_pkg.sv
// Shared types, constants and helpers for the inverse Clarke transform.
package inv_clark_tf_pkg;

  localparam int unsigned PKG_DATA_W = 16;

  // round(sqrt(3)/2 * 2^(w-1)) = round(sqrt(3*2^(2w-4))), via integer sqrt of 4x the radicand
  function automatic int unsigned inv_clark_k(input int unsigned w);
    longint unsigned n;
    longint unsigned r;
    longint unsigned b;
    n = 64'd3 << (2 * w - 2);
    r = 64'd0;
    for (int i = 31; i >= 0; i--) begin
      b = r | (64'd1 << i);
      if (b * b <= n) r = b;
    end
    return 32'((r + 64'd1) >> 1);
  endfunction

  localparam int unsigned INV_CLARK_K = inv_clark_k(PKG_DATA_W);

  // Clamp a signed value to the range of a signed width-bit number.
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] value,
                                                  input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

  typedef struct packed {
    logic signed [PKG_DATA_W-1:0] alpha;
    logic signed [PKG_DATA_W-1:0] beta;
  } ab_t;

  typedef struct packed {
    logic signed [PKG_DATA_W-1:0] ph_a;
    logic signed [PKG_DATA_W-1:0] ph_b;
    logic signed [PKG_DATA_W-1:0] ph_c;
  } abc_t;

endpackage

// File: rtl/inv_clark_tf_sat_clip.sv
// Signed saturator: narrows IN_W to OUT_W bits and flags when clipping occurred.
module sat_clip
  import inv_clark_tf_pkg::*;
#(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] sat_c,
  output logic                    clip_c
);

  logic signed [63:0] ext;
  logic signed [63:0] lim;

  assign ext    = 64'(din);
  assign lim    = sat_to_w(ext, OUT_W);
  assign sat_c  = OUT_W'(lim);
  assign clip_c = (lim != ext);

endmodule

// File: rtl/inv_clark_tf.sv
// Inverse Clarke transform: (alpha, beta) -> (a, b, c), 3-stage pipeline with
// valid/ready handshake, output saturation and a sticky saturation counter.
module inv_clark_tf
  import inv_clark_tf_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] alpha,
  input  logic signed [DATA_W-1:0] beta,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] ph_a,
  output logic signed [DATA_W-1:0] ph_b,
  output logic signed [DATA_W-1:0] ph_c,
  output logic                     sat_flag,
  output logic [CNT_W-1:0]         sat_cnt,
  input  logic                     sat_clr
);

  localparam int unsigned K  = inv_clark_k(DATA_W);
  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned WW = DATA_W + 2;
  localparam logic signed [PW-1:0] K_X = PW'(K);
  localparam logic signed [PW-1:0] RND = PW'(64'd1 << (DATA_W - 2));

  logic                     stall_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [WW-1:0]     h_c;
  logic signed [WW-1:0]     s_c;
  logic signed [DATA_W-1:0] b_sat_c;
  logic signed [DATA_W-1:0] c_sat_c;
  logic                     b_clip_c;
  logic                     c_clip_c;

  logic                     v1;
  logic signed [DATA_W-1:0] s1_alpha;
  logic signed [PW-1:0]     s1_prod;
  logic                     v2;
  logic signed [DATA_W-1:0] s2_a;
  logic signed [WW-1:0]     s2_b;
  logic signed [WW-1:0]     s2_c;

  assign stall_c  = out_valid && !out_ready;
  assign in_ready = !stall_c;

  assign prod_c = PW'(beta) * K_X;
  // Wide intermediate keeps -alpha/2 and the b/c sums exact before clipping.
  assign h_c    = WW'(s1_alpha) >>> 1;
  assign s_c    = WW'((s1_prod + RND) >>> (DATA_W - 1));

  sat_clip #(.IN_W(WW), .OUT_W(DATA_W)) u_sat_b (
    .din(s2_b), .sat_c(b_sat_c), .clip_c(b_clip_c)
  );

  sat_clip #(.IN_W(WW), .OUT_W(DATA_W)) u_sat_c (
    .din(s2_c), .sat_c(c_sat_c), .clip_c(c_clip_c)
  );

  // Pipeline: every stage advances together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_alpha  <= '0;
      s1_prod   <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_c      <= '0;
      ph_a      <= '0;
      ph_b      <= '0;
      ph_c      <= '0;
      sat_flag  <= 1'b0;
    end else if (!stall_c) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_alpha <= alpha;
        s1_prod  <= prod_c;
      end
      v2        <= v1;
      s2_a      <= s1_alpha;
      s2_b      <= s_c - h_c;
      s2_c      <= -h_c - s_c;
      out_valid <= v2;
      ph_a      <= s2_a;
      ph_b      <= b_sat_c;
      ph_c      <= c_sat_c;
      sat_flag  <= b_clip_c | c_clip_c;
    end
  end

  // Saturating count of clipped samples handed downstream; clear wins.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && sat_flag && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inv_clark_tf.sv
// Directed bench for inv_clark_tf with a scoreboard model and per-cycle checks.
module tb_inv_clark_tf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alpha;
  logic [15:0] beta;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ph_a;
  logic [15:0] ph_b;
  logic [15:0] ph_c;
  logic        sat_flag;
  logic [7:0]  sat_cnt;
  logic        sat_clr;

  int total = 0;
  int bad   = 0;

  logic [48:0] q[$];
  logic [7:0]  mcnt = 8'd0;
  logic        prev_stall = 1'b0;
  logic [49:0] prev_out;
  int          popped = 0;

  inv_clark_tf #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alpha(alpha), .beta(beta),
    .out_valid(out_valid), .out_ready(out_ready),
    .ph_a(ph_a), .ph_b(ph_b), .ph_c(ph_c),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: a = alpha, b/c = -alpha/2 +/- round(sqrt3/2*beta), clamped to 16 bits.
  function automatic logic [48:0] model(input logic [15:0] al, input logic [15:0] be);
    longint a, bt, h, s, b, c;
    logic f;
    a  = longint'($signed(al));
    bt = longint'($signed(be));
    h  = a >>> 1;
    s  = (bt * 28378 + 16384) >>> 15;
    b  = s - h;
    c  = -h - s;
    f  = 1'b0;
    if (b > 32767)  begin b = 32767;  f = 1'b1; end
    if (b < -32768) begin b = -32768; f = 1'b1; end
    if (c > 32767)  begin c = 32767;  f = 1'b1; end
    if (c < -32768) begin c = -32768; f = 1'b1; end
    return {al, b[15:0], c[15:0], f};
  endfunction

  // Per-cycle scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt       = 8'd0;
      prev_stall = 1'b0;
    end else begin
      logic [48:0] e;
      chk("sat_cnt", 64'(sat_cnt), 64'(mcnt));
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, ph_a, ph_b, ph_c, sat_flag}), 64'(prev_out));
      if (sat_clr) mcnt = 8'd0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          popped++;
          chk("out_data", 64'({ph_a, ph_b, ph_c, sat_flag}), 64'(e));
          if (!sat_clr && e[0] && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
        end
      end
      if (in_valid && in_ready) q.push_back(model(alpha, beta));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, ph_a, ph_b, ph_c, sat_flag};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single sample with out_ready=1: checks 3-clock latency and literal outputs.
  task automatic send_chk(input string nm, input logic [15:0] al, input logic [15:0] be,
                          input logic [48:0] exp);
    int n;
    in_valid = 1'b1;
    alpha    = al;
    beta     = be;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(3));
    chk(nm, 64'({ph_a, ph_b, ph_c, sat_flag}), 64'(exp));
  endtask

  logic [15:0] sa[8] = '{16'h4000, 16'h0000, 16'h8000, 16'h7FFF,
                         16'h1234, 16'hC000, 16'h8000, 16'h0100};
  logic [15:0] sb[8] = '{16'h0000, 16'h4000, 16'h7FFF, 16'h7FFF,
                         16'hF000, 16'h8000, 16'h8000, 16'h0200};

  initial begin
    int idx, cyc, p0, n;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; alpha = '0; beta = '0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_phases", 64'({ph_a, ph_b, ph_c, sat_flag}), 64'(0));
    chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    chk("model_v1", 64'(model(16'h4000, 16'h0000)), 64'({16'h4000, 16'hE000, 16'hE000, 1'b0}));
    chk("model_v2", 64'(model(16'h0000, 16'h4000)), 64'({16'h0000, 16'h376D, 16'hC893, 1'b0}));
    chk("model_v3", 64'(model(16'h8000, 16'h7FFF)), 64'({16'h8000, 16'h7FFF, 16'hD127, 1'b1}));
    chk("model_cclip", 64'(model(16'h7FFF, 16'h7FFF)), 64'({16'h7FFF, 16'h2EDA, 16'h8000, 1'b1}));

    send_chk("vec_alpha", 16'h4000, 16'h0000, {16'h4000, 16'hE000, 16'hE000, 1'b0});
    tick();
    send_chk("vec_beta", 16'h0000, 16'h4000, {16'h0000, 16'h376D, 16'hC893, 1'b0});
    tick();
    send_chk("vec_clip", 16'h8000, 16'h7FFF, {16'h8000, 16'h7FFF, 16'hD127, 1'b1});
    chk("vec_clip_cnt_before", 64'(sat_cnt), 64'(0));
    tick();
    chk("vec_clip_cnt_after", 64'(sat_cnt), 64'(1));
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr", 64'(sat_cnt), 64'(0));

    // Back-to-back stream with a 4-cycle downstream stall.
    p0 = popped; idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = 1'b1;
      alpha     = sa[idx];
      beta      = sb[idx];
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("stream_count", 64'(popped - p0), 64'(8));
    chk("stream_drained", 64'(q.size()), 64'(0));
    chk("stream_sat_cnt", 64'(sat_cnt), 64'(4));

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      alpha    = 16'h8000;
      beta     = 16'h7FFF;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_phases", 64'({ph_a, ph_b, ph_c, sat_flag}), 64'(0));
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    send_chk("post_rst", 16'h4000, 16'h0000, {16'h4000, 16'hE000, 16'hE000, 1'b0});
    tick();

    // Sticky counter ceiling, then clear racing a saturating handshake.
    in_valid = 1'b1;
    alpha    = 16'h8000;
    beta     = 16'h7FFF;
    repeat (260) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("sat_stick", 64'(sat_cnt), 64'(8'hFF));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("clr_race_valid", 64'({out_valid, sat_flag}), 64'(2'b11));
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clr_priority", 64'(sat_cnt), 64'(0));

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_clark_tf.md
Name: inv_clark_tf

Overview:
- Inverse Clarke transform: converts a stationary-frame (alpha, beta) voltage reference into three phase references (a, b, c) for the PWM modulator.
- Sits between the inverse-Park stage and the PWM/SVM block, opposite the forward Clarke stage on the current-sense path.
- Three-stage pipeline with valid/ready handshake on both sides, output saturation and a sticky saturation counter.

Parameters:
- DATA_W, 16, signed fixed-point width of all data ports (Q1.(DATA_W-1)).
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  alpha/beta valid.
- in_ready  out  1  block accepts input this cycle.
- alpha  in  DATA_W  signed alpha component.
- beta  in  DATA_W  signed beta component.
- out_valid  out  1  phase outputs valid.
- out_ready  in  1  downstream accepts outputs.
- ph_a  out  DATA_W  signed phase A reference.
- ph_b  out  DATA_W  signed phase B reference.
- ph_c  out  DATA_W  signed phase C reference.
- sat_flag  out  1  current output sample was clipped (qualified by out_valid).
- sat_cnt  out  CNT_W  count of clipped samples, saturating at all-ones.
- sat_clr  in  1  clears sat_cnt.

Behaviour:
- Math:
  - a = alpha.
  - b = -alpha/2 + K*beta.
  - c = -alpha/2 - K*beta.
  - K = round(sqrt(3)/2 * 2^(DATA_W-1)); for DATA_W = 16, K = 28378 (0x6EDA).
- Stage 1, on handshake:
  - register alpha and beta.
  - register prod = beta*K as a signed 2*DATA_W product.
  - v1 <= 1.
- Stage 2:
  - h = alpha >>> 1 (arithmetic).
  - s = (prod + 2^(DATA_W-2)) >>> (DATA_W-1), round half up.
  - b_w = -h + s and c_w = -h - s, computed in DATA_W+2 bits.
  - a_w = alpha.
  - v2 <= v1.
- Stage 3: saturate b_w and c_w to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; register ph_a/ph_b/ph_c, sat_flag (either clipped) and out_valid <= v2.
- Latency: 3 cycles from the in_valid&&in_ready edge to out_valid with no stall. Throughput is 1 sample/clk.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, all stage registers and valid bits hold.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Bubbles: the valid bits propagate independently. Data registers of invalid stages may change; outputs are don't-care while out_valid=0.
- sat_cnt:
  - Increments by 1 on each output handshake (out_valid && out_ready) with sat_flag=1.
  - Holds at 2^CNT_W-1.
  - sat_clr has priority over increment in the same cycle; it sets the counter to 0.
- Reset (any cycle, including mid-stream):
  - all valid bits 0.
  - ph_a = ph_b = ph_c = 0, sat_flag = 0, sat_cnt = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
  - In-flight samples are discarded.
- Boundary values:
  - alpha = -2^(DATA_W-1): h is exact (no overflow) because of the wide intermediate.
  - ph_a never saturates.
  - Only b and c can clip.

Decomposition:
- Shared package gets:
  - K (INV_CLARK_K) as a localparam function of DATA_W.
  - A saturation helper function sat_to_w(value, width).
  - A struct type for the abc triplet (ph_a, ph_b, ph_c), beside the existing alpha/beta pair type.
- One natural sub-module: sat_clip, a parameterised signed saturator returning the clipped value and a clip flag. It is instantiated twice, for b and c.
- Pipeline and handshake logic stay in the top.

Test Plan:
- alpha=0x4000, beta=0, out_ready=1 -> after 3 clks: ph_a=0x4000, ph_b=0xE000, ph_c=0xE000, sat_flag=0.
- alpha=0, beta=0x4000 -> ph_a=0, ph_b=0x376D (14189), ph_c=0xC893 (-14189), sat_flag=0.
- alpha=0x8000, beta=0x7FFF -> ph_a=0x8000, ph_b=0x7FFF (clipped), ph_c=0xD127; sat_flag=1; sat_cnt 0->1 on handshake; sat_clr pulse -> sat_cnt=0.
- Stream 8 back-to-back samples with out_ready low for 4 clks mid-stream:
  - in_ready drops the cycle stall asserts.
  - outputs hold.
  - no sample is lost or duplicated.
  - order is preserved against the reference model.
- Assert rst while 3 samples are in flight -> next cycle out_valid=0, outputs 0, sat_cnt=0, in_ready=1; the first post-reset sample emerges 3 clks after acceptance.
- 256+ consecutive saturating samples -> sat_cnt sticks at 0xFF; sat_clr and a saturating handshake in the same cycle -> sat_cnt=0.
